cycle_counter_display: RTL and testbench

Counts completed process cycles reported by the sequencing FSM's one-cycle `count` pulse and shows the total on a 4-digit multiplexed seven-segment display. It sits directly downstream of the FSM: its `count_in` input is wired to the FSM's `count` output, in the same clock domain. The block holds a 4-digit BCD total with a sticky overflow flag and drives the board's anode and segment lines through a time-multiplexed scanner.

---
 rtl/cycle_counter_display.sv | 142 ++++++++++++++
 tb/tb_cycle_counter_display.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cycle_counter_display.sv
// Counts rising edges of the FSM count strobe as a 4-digit BCD total
// and scans it onto a multiplexed active-low seven-segment display.
module cycle_counter_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_in,
  input  logic        clear,
  output logic [15:0] bcd_value,
  output logic        overflow,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic          cnt_d_q;
  logic [15:0]   bcd_q, bcd_d, bcd_inc;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          inc, wrap, tick;
  logic [3:0]    dsel;
  logic          blank;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign inc = count_in & ~cnt_d_q;

  // Ripple decimal carry; wrap is the carry out of digit3.
  always_comb begin
    logic       c;
    logic [3:0] dg;
    bcd_inc = bcd_q;
    c       = inc;
    for (int i = 0; i < 4; i++) begin
      dg = bcd_q[4*i +: 4];
      if (c) begin
        if (dg == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = dg + 4'd1;
          c = 1'b0;
        end
      end
    end
    wrap = c;
  end

  always_comb begin
    bcd_d = bcd_inc;
    ovf_d = ovf_q | wrap;
    if (clear) begin
      bcd_d = 16'h0000;
      ovf_d = 1'b0;
    end
  end

  assign tick   = (scan_q == LAST);
  assign scan_d = tick ? '0 : scan_q + 1'b1;
  assign idx_d  = tick ? idx_q + 2'd1 : idx_q;

  always_comb begin
    dsel  = bcd_q[3:0];
    blank = 1'b0;
    unique case (idx_q)
      2'd0: begin
        dsel  = bcd_q[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        dsel  = bcd_q[7:4];
        blank = (bcd_q[15:4] == 12'h000);
      end
      2'd2: begin
        dsel  = bcd_q[11:8];
        blank = (bcd_q[15:8] == 8'h00);
      end
      2'd3: begin
        dsel  = bcd_q[15:12];
        blank = (bcd_q[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? 7'b1111111 : seg_of(dsel);
    dp_d  = ~((idx_q == 2'd3) & ovf_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_d_q <= 1'b0;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
      scan_q  <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
      dp_q    <= 1'b1;
    end else begin
      cnt_d_q <= count_in;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bcd_value = bcd_q;
  assign overflow  = ovf_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;

endmodule

// File: tb/tb_cycle_counter_display.sv
// Bench for cycle_counter_display: integer-total reference model,
// directed plan steps plus random strobe/clear traffic, SCAN_DIV=4.
module tb_cycle_counter_display;

  localparam int SD = 4;

  logic        clk;
  logic        rst;
  logic        count_in;
  logic        clear;
  logic [15:0] bcd_value;
  logic        overflow;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int total;
  int bad;

  int m_tot;
  bit m_ovf;
  bit m_prev;
  int m_k;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  logic [6:0] pat [10];

  cycle_counter_display #(.SCAN_DIV(SD)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .clear     (clear),
    .bcd_value (bcd_value),
    .overflow  (overflow),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tot  = 0;
    m_ovf  = 0;
    m_prev = 0;
    m_k    = 0;
    e_an   = 4'b1110;
    e_seg  = 7'b1000000;
    e_dp   = 1'b1;
  endtask

  task automatic step(input logic ci, input logic cl);
    int i;
    int dv;
    count_in = ci;
    clear    = cl;
    i  = (m_k / SD) % 4;
    dv = (m_tot / (10 ** i)) % 10;
    e_an  = ~(4'b0001 << i);
    e_seg = (i > 0 && m_tot < 10 ** i) ? 7'b1111111 : pat[dv];
    e_dp  = !(i == 3 && m_ovf);
    @(posedge clk);
    if (cl) begin
      m_tot = 0;
      m_ovf = 0;
    end else if (ci && !m_prev) begin
      if (m_tot == 9999) m_ovf = 1;
      m_tot = (m_tot + 1) % 10000;
    end
    m_prev = ci;
    m_k++;
    #1;
    chk("bcd", bcd_value, to_bcd(m_tot));
    chk("ovf", 16'(overflow), 16'(m_ovf));
    chk("an", 16'(an), 16'(e_an));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("dp", 16'(dp), 16'(e_dp));
  endtask

  task automatic pulses(input int n, input int gap);
    for (int p = 0; p < n; p++) begin
      step(1'b1, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bcd"}, bcd_value, 16'h0000);
    chk({tag, "_ovf"}, 16'(overflow), 16'h0);
    chk({tag, "_an"}, 16'(an), 16'hE);
    chk({tag, "_seg"}, 16'(seg), 16'h40);
    chk({tag, "_dp"}, 16'(dp), 16'h1);
  endtask

  initial begin
    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000};
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    count_in = 1'b0;
    clear    = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_vals("rst0");
    @(posedge clk);
    @(posedge clk);
    #1 chk_reset_vals("rst1");
    rst = 1'b1;
    model_reset();

    pulses(12, 2);
    chk("twelve", bcd_value, 16'h0012);
    chk("twelve_ovf", 16'(overflow), 16'h0);

    step(1'b0, 1'b1);
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0);
    chk("held", bcd_value, 16'h0001);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("held_next", bcd_value, 16'h0002);

    step(1'b0, 1'b1);
    pulses(9998, 1);
    chk("pre9998", bcd_value, 16'h9998);
    pulses(1, 1);
    chk("at9999", bcd_value, 16'h9999);
    pulses(1, 1);
    chk("wrap", bcd_value, 16'h0000);
    chk("wrap_ovf", 16'(overflow), 16'h1);
    for (int c = 0; c < 4 * SD + 2; c++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("clr_ovf", 16'(overflow), 16'h0);

    pulses(41, 1);
    chk("at41", bcd_value, 16'h0041);
    step(1'b1, 1'b1);
    chk("clr_prio", bcd_value, 16'h0000);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("after_prio", bcd_value, 16'h0001);

    step(1'b0, 1'b1);
    pulses(305, 1);
    chk("at305", bcd_value, 16'h0305);
    for (int c = 0; c < 5 * SD; c++) step(1'b0, 1'b0);

    for (int c = 0; c < 400; c++)
      step(1'($urandom % 2), 1'($urandom % 25 == 0));

    step(1'b0, 1'b1);
    pulses(7, 1);
    while ((m_k / SD) % 4 != 2) step(1'b0, 1'b0);
    @(posedge clk);
    count_in = 1'b1;
    #2 rst = 1'b0;
    #1 chk_reset_vals("midrst");
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    step(1'b1, 1'b0);
    chk("rel_high", bcd_value, 16'h0001);
    for (int c = 0; c < 4 * SD + 3; c++) step(1'b0, 1'b0);
    pulses(20, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
